multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath select and write-enable lines: PC, IR, register file, ALU operand muxes, immediate-consuming paths and memory port. It sits beside the datapath, consumes the latched instruction word and the branch comparator result, and owns the single memory handshake shared by instruction fetch and data access.

## Interface
- `MEM_WAIT_MAX`, default 15: maximum consecutive cycles `mem_req` may wait for `mem_ready` before trapping. A value of 0 disables the timeout.

- `clk` in 1: the single clock. One clock; all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `instr` in 32: IR contents. Valid from DECODE onward.
- `br_taken` in 1: branch comparator result. Valid in EXEC.
- `mem_ready` in 1: memory completes the transfer this cycle.
- `mem_req` out 1: memory request.
- `mem_we` out 1: store when 1.
- `mem_sel` out 1: address source. 0 = PC, 1 = ALU result.
- `ir_we` out 1: latch `instr` from memory read data.
- `pc_we` out 1: PC update.
- `pc_src` out 2: next-PC source. 00 = PC+4, 01 = PC+eximm, 10 = ALU & ~1.
- `reg_we` out 1: register-file write.
- `wb_sel` out 2: writeback source. 00 = ALU, 01 = mem data, 10 = PC+4, 11 = eximm.
- `alu_a_sel` out 1: 0 = rs1, 1 = PC.
- `alu_b_sel` out 1: 0 = rs2, 1 = eximm.
- `alu_mode` out 2: 00 = add, 01 = funct3/funct7-decoded, 10 = compare.
- `instr_retired` out 1: one-cycle pulse per completed instruction.
- `halted` out 1: sticky trap indicator.
- `trap_cause` out 2: 00 = none, 01 = illegal opcode, 10 = memory timeout.

## Operation
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Moore outputs decoded from the state register, plus a registered opcode class captured in DECODE. The only Mealy terms are the `mem_ready` qualifications and `pc_src` in EXEC for branches.
- **BOOT:** all outputs 0. Next state FETCH unconditionally.
- **FETCH:** `mem_req`=1, `mem_sel`=0. On `mem_ready`: `ir_we`=1, go to DECODE. Otherwise hold.
- **DECODE:** classify `instr[6:0]`.
  - LUI → WB.
  - JAL → WB.
  - R, I-ALU, AUIPC, JALR, branch, load, store → EXEC.
  - Any other opcode, including FENCE and SYSTEM → TRAP with cause 01.
- **EXEC:**
  - R: `alu_b_sel`=0, `alu_mode`=01.
  - I-ALU: `alu_b_sel`=1, `alu_mode`=01.
  - AUIPC: `alu_a_sel`=1, `alu_b_sel`=1, add.
  - JALR, load, store: rs1 + eximm, add.
  - Branch: `alu_mode`=10, `pc_we`=1, `pc_src` = `br_taken` ? 01 : 00, retire, go to FETCH.
  - Load and store go to MEM; all others go to WB.
- **MEM:** `mem_req`=1, `mem_sel`=1, `mem_we`=1 for stores. ALU operand selects held from EXEC so the address stays stable. On `mem_ready`:
  - Load → WB.
  - Store → `pc_we`=1, `pc_src`=00, retire, go to FETCH.
- **WB:** `pc_we`=1 and retire in every case, then go to FETCH.
  - LUI: `reg_we`=1, `wb_sel`=11, `pc_src`=00.
  - JAL: `reg_we`=1, `wb_sel`=10, `pc_src`=01.
  - JALR: `wb_sel`=10, `pc_src`=10.
  - Load: `wb_sel`=01, `pc_src`=00.
  - R, I-ALU, AUIPC: `wb_sel`=00, `pc_src`=00.
- **TRAP:** all control outputs 0, `halted`=1, `trap_cause` held. Exit only by reset.
- **Memory timeout:** a wait counter increments each cycle that `mem_req`=1 and `mem_ready`=0. It clears on completion and on state change.
  - When the counter equals `MEM_WAIT_MAX` (nonzero) in FETCH or MEM, go to TRAP with cause 10. `mem_req` drops that same edge.
  - Counter width is $clog2(MEM_WAIT_MAX+1). It saturates and never wraps.
- **Invariants:**
  - `pc_we` is asserted exactly once per instruction, and only in the cycle `instr_retired`=1.
  - `reg_we` is never 1 together with `mem_req`.
  - `ir_we` is only ever 1 in FETCH.

## Timing
- **Reset values:** all outputs 0, state BOOT, `trap_cause`=00, counter 0.
  - Assertion of `rst` forces this immediately, regardless of phase. An in-flight `mem_req` drops asynchronously, and no partial write is retired.
- **Latency with zero-wait memory** (`mem_ready` high in the first request cycle):
  - Branch: 3 cycles.
  - LUI, JAL: 3 cycles.
  - R, I-ALU, AUIPC, JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- **Handshake:** the transfer completes on the edge where `mem_req` and `mem_ready` are both 1.
  - While `mem_req` is 1, `mem_sel` and `mem_we` are stable.
  - `mem_ready` is ignored when `mem_req`=0.
- **Timeout boundary:** `mem_ready` arriving in the same cycle the counter hits `MEM_WAIT_MAX` counts as success, not a trap.

## Structure
- Package `rv32_ctrl_pkg` holds:
  - the opcode constants (R, I-ALU, S, B, LUI, AUIPC, JAL, JALR, LOAD), shared with the immediate generator;
  - the state encoding;
  - the `pc_src`, `wb_sel` and `alu_mode` encodings;
  - the `trap_cause` codes.
- Sub-module `op_classify`: combinational, maps opcode to a one-hot class plus an illegal flag.
- FSM and timeout counter live in `multicycle_ctrl`.

## Test plan
- **ADD, zero-wait:** `instr`=0x002081B3 → DECODE → EXEC `alu_mode`=01 → WB `reg_we`=1, `wb_sel`=00, `pc_we`=1. Retire at cycle 4.
- **Taken BEQ:** 0x00208463, `br_taken`=1 → EXEC `pc_we`=1, `pc_src`=01, no `reg_we`. Cycle 3. Repeat with `br_taken`=0 → `pc_src`=00.
- **LW with 2 wait cycles in MEM:** `mem_sel`=1 held for 3 cycles → WB `wb_sel`=01. Retire at cycle 7.
- **Illegal opcode 0x0000007F:** TRAP, `halted`=1, `trap_cause`=01. Stays halted 20 cycles until `rst`.
- **`MEM_WAIT_MAX`=3, fetch never ready:** TRAP cause 10 after 3 wait cycles. With `mem_ready` arriving in wait cycle 3 instead: normal DECODE.
- **`rst` asserted mid-MEM store:** outputs 0 in the same cycle, no `pc_we`/`instr_retired`. After release: BOOT then FETCH.

Source files
------------

// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg: encodings shared by the RV32I multi-cycle control path
// and the datapath blocks that consume its select lines.
package rv32_ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    typedef enum logic [2:0] {
        S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_e;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_FUNC = 2'b01;
    localparam logic [1:0] ALU_CMP  = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    typedef struct packed {
        logic r;
        logic i;
        logic auipc;
        logic jalr;
        logic branch;
        logic load;
        logic store;
        logic lui;
        logic jal;
    } opclass_t;

    typedef struct packed {
        logic       a_sel;
        logic       b_sel;
        logic [1:0] mode;
    } alu_ctrl_t;

    // Operand selects are a pure function of the class so they can be
    // re-issued unchanged in every post-decode state.
    function automatic alu_ctrl_t alu_ctrl(input opclass_t c);
        alu_ctrl_t a;
        a = '0;
        unique case (1'b1)
            c.r:                       a = '{1'b0, 1'b0, ALU_FUNC};
            c.i:                       a = '{1'b0, 1'b1, ALU_FUNC};
            c.auipc:                   a = '{1'b1, 1'b1, ALU_ADD};
            c.jalr, c.load, c.store:   a = '{1'b0, 1'b1, ALU_ADD};
            c.branch:                  a = '{1'b0, 1'b0, ALU_CMP};
            default:                   a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/op_classify.sv
// op_classify: maps an RV32I major opcode to a one-hot class and
// flags everything outside the supported subset as illegal.
module op_classify
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output opclass_t   cls_o,
    output logic       illegal_o
);

    always_comb begin
        cls_o     = '0;
        illegal_o = 1'b0;
        unique case (opcode_i)
            OP_R:     cls_o.r      = 1'b1;
            OP_I:     cls_o.i      = 1'b1;
            OP_AUIPC: cls_o.auipc  = 1'b1;
            OP_JALR:  cls_o.jalr   = 1'b1;
            OP_B:     cls_o.branch = 1'b1;
            OP_LOAD:  cls_o.load   = 1'b1;
            OP_S:     cls_o.store  = 1'b1;
            OP_LUI:   cls_o.lui    = 1'b1;
            OP_JAL:   cls_o.jal    = 1'b1;
            default:  illegal_o    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/wb sequencer for the RV32I core,
// owning the shared memory handshake and its wait timeout.
module multicycle_ctrl
    import rv32_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_mode,
    output logic        instr_retired,
    output logic        halted,
    output logic [1:0]  trap_cause
);

    localparam int CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    state_e      state_q, state_d;
    opclass_t    cls_q, cls_d;
    logic [1:0]  cause_q, cause_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic        timeout;
    opclass_t    dec_cls;
    logic        dec_illegal;
    alu_ctrl_t   alu;
    logic        unused_instr;

    assign unused_instr = ^instr[31:7];

    op_classify u_cls (
        .opcode_i  (instr[6:0]),
        .cls_o     (dec_cls),
        .illegal_o (dec_illegal)
    );

    // Trap on the wait cycle that would bring the count to the limit;
    // a ready in that same cycle still wins.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign timeout = (MEM_WAIT_MAX != 0) && !mem_ready
                     && (cnt_inc == CW'(MEM_WAIT_MAX));

    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        cause_d       = cause_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_sel       = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_src        = PC_PLUS4;
        reg_we        = 1'b0;
        wb_sel        = WB_ALU;
        alu           = '0;
        instr_retired = 1'b0;
        unique case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = TRAP_TIMEOUT;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                if (dec_illegal) begin
                    state_d = S_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end else if (dec_cls.lui || dec_cls.jal) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu = alu_ctrl(cls_q);
                if (cls_q.branch) begin
                    pc_we         = 1'b1;
                    pc_src        = br_taken ? PC_BRANCH : PC_PLUS4;
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end else if (cls_q.load || cls_q.store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                alu     = alu_ctrl(cls_q);
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = cls_q.store;
                if (mem_ready) begin
                    if (cls_q.store) begin
                        pc_we         = 1'b1;
                        instr_retired = 1'b1;
                        state_d       = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = TRAP_TIMEOUT;
                end
            end
            S_WB: begin
                alu           = alu_ctrl(cls_q);
                pc_we         = 1'b1;
                reg_we        = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
                unique case (1'b1)
                    cls_q.lui:  wb_sel = WB_IMM;
                    cls_q.jal: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_BRANCH;
                    end
                    cls_q.jalr: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_ALU;
                    end
                    cls_q.load: wb_sel = WB_MEM;
                    default:    wb_sel = WB_ALU;
                endcase
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (mem_req && !mem_ready && state_d == state_q)
            cnt_d = cnt_inc;
    end

    assign alu_a_sel  = alu.a_sel;
    assign alu_b_sel  = alu.b_sel;
    assign alu_mode   = alu.mode;
    assign halted     = (state_q == S_TRAP);
    assign trap_cause = cause_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
            cls_q   <= '0;
            cause_q <= TRAP_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table vectors, instruction-level random model and
// directed timeout/trap/reset sequences for multicycle_ctrl.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       req;
        logic       we;
        logic       sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       a_sel;
        logic       b_sel;
        logic [1:0] mode;
        logic       retired;
        logic       halted;
        logic [1:0] cause;
    } out_t;

    typedef struct packed {
        logic rdy;
        out_t o;
    } step_t;

    typedef struct {
        logic [31:0] ins;
        logic        tk;
        int          fw;
        int          mw;
        int          lat;
        logic [1:0]  pcs;
        logic [1:0]  wbs;
        logic        rwe;
    } vec_t;

    localparam int TRAPN = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        br_taken;
    logic        mem_ready;

    logic mem_req, mem_we, mem_sel, ir_we, pc_we, reg_we;
    logic alu_a_sel, alu_b_sel, instr_retired, halted;
    logic [1:0] pc_src, wb_sel, alu_mode, trap_cause;
    logic mem_req3, mem_we3, mem_sel3, ir_we3, pc_we3, reg_we3;
    logic alu_a_sel3, alu_b_sel3, instr_retired3, halted3;
    logic [1:0] pc_src3, wb_sel3, alu_mode3, trap_cause3;

    out_t o15, o3;
    step_t q[$];
    int ntests = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .br_taken(br_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_sel(mem_sel), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .alu_mode(alu_mode), .instr_retired(instr_retired),
        .halted(halted), .trap_cause(trap_cause)
    );

    multicycle_ctrl #(.MEM_WAIT_MAX(3)) dut3 (
        .clk(clk), .rst(rst), .instr(instr), .br_taken(br_taken),
        .mem_ready(mem_ready), .mem_req(mem_req3), .mem_we(mem_we3),
        .mem_sel(mem_sel3), .ir_we(ir_we3), .pc_we(pc_we3),
        .pc_src(pc_src3), .reg_we(reg_we3), .wb_sel(wb_sel3),
        .alu_a_sel(alu_a_sel3), .alu_b_sel(alu_b_sel3),
        .alu_mode(alu_mode3), .instr_retired(instr_retired3),
        .halted(halted3), .trap_cause(trap_cause3)
    );

    assign o15 = {mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src, reg_we,
                  wb_sel, alu_a_sel, alu_b_sel, alu_mode, instr_retired,
                  halted, trap_cause};
    assign o3 = {mem_req3, mem_we3, mem_sel3, ir_we3, pc_we3, pc_src3,
                 reg_we3, wb_sel3, alu_a_sel3, alu_b_sel3, alu_mode3,
                 instr_retired3, halted3, trap_cause3};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_o(input string name, input int idx,
                           input out_t got, input out_t exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s[%0d]: got %h want %h", name, idx, got, exp);
        end
    endtask

    task automatic check_i(input string name, input int idx,
                           input int got, input int exp);
        ntests++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s[%0d]: got %0d want %0d", name, idx, got, exp);
        end
    endtask

    function automatic out_t alu_rec(input logic a, input logic b,
                                     input logic [1:0] m);
        out_t o;
        o = '0;
        o.a_sel = a;
        o.b_sel = b;
        o.mode  = m;
        return o;
    endfunction

    function automatic out_t retire(input out_t i);
        out_t o;
        o = i;
        o.pc_we   = 1'b1;
        o.retired = 1'b1;
        return o;
    endfunction

    task automatic push(input out_t o, input logic rdy);
        step_t s;
        s.rdy = rdy;
        s.o   = o;
        q.push_back(s);
    endtask

    task automatic push_trap(input logic [1:0] cause);
        out_t t;
        t = '0;
        t.halted = 1'b1;
        t.cause  = cause;
        for (int k = 0; k < TRAPN; k++) push(t, rb());
    endtask

    // w not-ready request cycles; reaching maxw of them traps instead
    task automatic push_req(input out_t o, input int w, input int maxw,
                            output bit trapped);
        int n;
        trapped = (maxw != 0) && (w >= maxw);
        n = trapped ? maxw : w;
        for (int k = 0; k < n; k++) push(o, 1'b0);
        if (trapped) push_trap(2'b10);
    endtask

    // Expected per-cycle outputs for one instruction, starting in FETCH
    task automatic build(input logic [31:0] ins, input logic tk,
                         input int fw, input int mw, input int maxw);
        out_t z, f, e, m, w;
        bit tr;
        z = '0;
        f = z;
        f.req = 1'b1;
        push_req(f, fw, maxw, tr);
        if (tr) return;
        f.ir_we = 1'b1;
        push(f, 1'b1);
        push(z, rb());
        e = z;
        case (ins[6:0])
            7'h37: begin
                w = z; w.reg_we = 1'b1; w.wb_sel = 2'b11;
                push(retire(w), rb());
            end
            7'h6F: begin
                w = z; w.reg_we = 1'b1; w.wb_sel = 2'b10; w.pc_src = 2'b01;
                push(retire(w), rb());
            end
            7'h63: begin
                e = alu_rec(1'b0, 1'b0, 2'b10);
                e.pc_src = tk ? 2'b01 : 2'b00;
                push(retire(e), rb());
            end
            7'h33, 7'h13, 7'h17: begin
                if (ins[6:0] == 7'h33) e = alu_rec(1'b0, 1'b0, 2'b01);
                else if (ins[6:0] == 7'h13) e = alu_rec(1'b0, 1'b1, 2'b01);
                else e = alu_rec(1'b1, 1'b1, 2'b00);
                push(e, rb());
                w = e; w.reg_we = 1'b1;
                push(retire(w), rb());
            end
            7'h67: begin
                e = alu_rec(1'b0, 1'b1, 2'b00);
                push(e, rb());
                w = e; w.reg_we = 1'b1; w.wb_sel = 2'b10; w.pc_src = 2'b10;
                push(retire(w), rb());
            end
            7'h03: begin
                e = alu_rec(1'b0, 1'b1, 2'b00);
                push(e, rb());
                m = e; m.req = 1'b1; m.sel = 1'b1;
                push_req(m, mw, maxw, tr);
                if (tr) return;
                push(m, 1'b1);
                w = e; w.reg_we = 1'b1; w.wb_sel = 2'b01;
                push(retire(w), rb());
            end
            7'h23: begin
                e = alu_rec(1'b0, 1'b1, 2'b00);
                push(e, rb());
                m = e; m.req = 1'b1; m.sel = 1'b1; m.we = 1'b1;
                push_req(m, mw, maxw, tr);
                if (tr) return;
                push(retire(m), 1'b1);
            end
            default: push_trap(2'b01);
        endcase
    endtask

    task automatic run_q(input bit use3, input string tag);
        step_t s;
        int idx;
        idx = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            mem_ready = s.rdy;
            #1;
            check_o(tag, idx, use3 ? o3 : o15, s.o);
            idx++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        check_o("reset", 0, o15, '0);
        check_o("reset3", 0, o3, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_o("boot", 0, o15, '0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, left, npc;
        bit done;
        logic [1:0] pcs, wbs;
        logic rwe;
        cyc = 0; npc = 0; done = 0; left = v.fw;
        pcs = 2'bxx; wbs = 2'bxx; rwe = 1'bx;
        instr = v.ins;
        br_taken = v.tk;
        while (!done && cyc < 60) begin
            @(negedge clk);
            mem_ready = mem_req ? (left == 0) : rb();
            #1;
            cyc++;
            if (pc_we) npc++;
            if (mem_req) left = mem_ready ? v.mw : left - 1;
            if (instr_retired) begin
                done = 1;
                pcs = pc_src; wbs = wb_sel; rwe = reg_we;
            end
        end
        check_i("latency", idx, cyc, v.lat);
        check_i("pc_src", idx, int'(pcs), int'(v.pcs));
        check_i("wb_sel", idx, int'(wbs), int'(v.wbs));
        check_i("reg_we", idx, int'(rwe), int'(v.rwe));
        check_i("pc_we_count", idx, npc, 1);
    endtask

    initial begin
        vec_t vt[12];
        logic [6:0] ops[9];
        logic [31:0] ill[3];
        out_t x;
        logic [6:0] op;
        logic tk;

        rst = 1'b1; instr = '0; br_taken = 1'b0; mem_ready = 1'b0;
        vt[0]  = '{32'h002081B3, 1'b0, 0, 0, 4, 2'b00, 2'b00, 1'b1};
        vt[1]  = '{32'h00208463, 1'b1, 0, 0, 3, 2'b01, 2'b00, 1'b0};
        vt[2]  = '{32'h00208463, 1'b0, 0, 0, 3, 2'b00, 2'b00, 1'b0};
        vt[3]  = '{32'h0000A103, 1'b0, 0, 2, 7, 2'b00, 2'b01, 1'b1};
        vt[4]  = '{32'h123450B7, 1'b0, 0, 0, 3, 2'b00, 2'b11, 1'b1};
        vt[5]  = '{32'h0080006F, 1'b1, 0, 0, 3, 2'b01, 2'b10, 1'b1};
        vt[6]  = '{32'h0020A023, 1'b0, 0, 0, 4, 2'b00, 2'b00, 1'b0};
        vt[7]  = '{32'h000080E7, 1'b0, 0, 0, 4, 2'b10, 2'b10, 1'b1};
        vt[8]  = '{32'h00001097, 1'b0, 0, 0, 4, 2'b00, 2'b00, 1'b1};
        vt[9]  = '{32'h00108093, 1'b0, 2, 0, 6, 2'b00, 2'b00, 1'b1};
        vt[10] = '{32'h123450B7, 1'b0, 14, 0, 17, 2'b00, 2'b11, 1'b1};
        vt[11] = '{32'h0020A023, 1'b0, 1, 3, 8, 2'b00, 2'b00, 1'b0};
        ops = '{7'h33, 7'h13, 7'h17, 7'h67, 7'h63,
                7'h03, 7'h23, 7'h37, 7'h6F};
        ill = '{32'h0000007F, 32'h0000000F, 32'h00000073};

        do_reset();
        for (int i = 0; i < 12; i++) run_vec(vt[i], i);

        do_reset();
        for (int n = 0; n < 150; n++) begin
            op = ops[$urandom_range(0, 8)];
            tk = rb();
            instr = {25'($urandom), op};
            br_taken = tk;
            build(instr, tk, $urandom_range(0, 3), $urandom_range(0, 3), 15);
            run_q(1'b0, "random");
        end

        for (int i = 0; i < 3; i++) begin
            do_reset();
            instr = ill[i];
            build(instr, 1'b0, 0, 0, 15);
            run_q(1'b0, "illegal");
        end

        do_reset();
        instr = 32'h00000013;
        build(instr, 1'b0, 3, 0, 3);
        run_q(1'b1, "fetch_timeout");
        do_reset();
        build(instr, 1'b0, 2, 0, 3);
        run_q(1'b1, "fetch_edge");
        do_reset();
        instr = 32'h0000A103;
        build(instr, 1'b0, 0, 3, 3);
        run_q(1'b1, "mem_timeout");
        do_reset();
        build(instr, 1'b0, 0, 2, 3);
        run_q(1'b1, "mem_edge");

        do_reset();
        instr = 32'h0020A023;
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        x = alu_rec(1'b0, 1'b1, 2'b00);
        x.req = 1'b1; x.sel = 1'b1; x.we = 1'b1;
        check_o("store_mem", 0, o15, x);
        #2 rst = 1'b1;
        #1 check_o("rst_async", 0, o15, '0);
        @(posedge clk);
        #1 check_o("rst_hold", 0, o15, '0);
        @(negedge clk);
        rst = 1'b0;
        #1 check_o("rst_boot", 0, o15, '0);
        @(negedge clk);
        #1;
        x = '0;
        x.req = 1'b1;
        check_o("rst_fetch", 0, o15, x);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
